regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
Write-side front end for the dual-port register file shared by core A and core B. Each core pushes writeback requests (register, data) through a valid/ready handshake into a private FIFO. The scheduler drains both FIFOs onto the register file's two write ports, serialising same-register collisions with round-robin priority. It also exports a pending-write mask for hazard/stall logic.

Parameters:
DEPTH, 4, entries per core FIFO (power of two, ≥2)
AW, 5, register address width
DW, 32, data width

Ports:
CLK  input  1  clock; all state updates on posedge CLK
RST_N  input  1  asynchronous active-low reset
A_VALID  input  1  core A writeback request valid
A_READY  output  1  core A request accepted this edge when A_VALID&A_READY
A_ADDR  input  AW  core A destination register
A_DATA  input  DW  core A write data
B_VALID  input  1  core B request valid
B_READY  output  1  core B ready
B_ADDR  input  AW  core B destination register
B_DATA  input  DW  core B write data
WEA3  output  1  register file port A write enable (registered)
A3  output  AW  port A write address (registered)
WDA3  output  DW  port A write data (registered)
WEB3  output  1  port B write enable (registered)
B3  output  AW  port B write address (registered)
WDB3  output  DW  port B write data (registered)
A_COUNT  output  $clog2(DEPTH+1)  core A FIFO occupancy
B_COUNT  output  $clog2(DEPTH+1)  core B FIFO occupancy
PEND_MASK  output  32  bit r set while a write to register r is queued or on the write port

Behaviour:
- Reset (RST_N low, asynchronous): both FIFOs empty, counts 0, WEA3/WEB3=0, A3/B3/WDA3/WDB3=0, priority=A, PEND_MASK=0. Reset mid-operation discards all queued writes; nothing is issued on the edge after release.
- A_READY = (A_COUNT != DEPTH); same for B. Push and pop on the same edge when full: no push (READY is low regardless of the pop).
- Request with ADDR==0 and VALID&READY: handshake completes, entry discarded (not enqueued, count unchanged).
- Per-core FIFO order preserved. Circular pointers wrap at DEPTH.
- Issue at each posedge, using FIFO heads before the edge:
  - A non-empty, B empty: pop A; WEA3=1, A3/WDA3=head A; WEB3=0.
  - B non-empty, A empty: symmetric, on port B only.
  - Both non-empty, addresses differ: pop both; drive both ports.
  - Both non-empty, addresses equal: pop only the priority side onto its own port; the other port WE=0. Priority then toggles. Priority changes only on collisions.
  - Both empty: WEA3=WEB3=0. Address/data registers hold their last values.
- Port mapping is fixed: core A entries always go out on port A, core B entries always on port B.
- Latency: entry accepted at edge t into an empty FIFO is issued at edge t+1. WE is high from t+1 to t+2, and the register file writes at the negedge inside that cycle. No combinational pass-through.
- WE outputs are high for exactly one cycle per issued entry.
- Throughput: 1 write/cycle per port without collisions.
- PEND_MASK (combinational from state): OR of decoded addresses of all valid entries in both FIFOs, plus A3 if WEA3, plus B3 if WEB3. Bit 0 is always 0.
- COUNT = push − pop per edge. Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.

Test Plan:
- Reset: drive RST_N low mid-stream with 3 entries queued -> WEA3=WEB3=0, A_COUNT=B_COUNT=0, PEND_MASK=0 immediately (before next edge); no writes after release.
- Single write: A pushes (r5, 0xDEADBEEF) at edge t -> at t+1 WEA3=1, A3=5, WDA3=0xDEADBEEF for one cycle. PEND_MASK[5]=1 from after t until after t+2.
- Parallel: A pushes r3=1, B pushes r4=2 on the same edge -> both ports fire on the next edge with those values.
- Collision fairness: A queues r7=0xA1 and r7=0xA2; B queues r7=0xB1 and r7=0xB2 -> issue order A(0xA1), B(0xB1), A(0xA2), B(0xB2) on their own ports, one per cycle, and the final r7 is 0xB2.
- Full/backpressure: push 4 entries to A with no issue blocked? No. Instead hold B with collisions so that A accepts DEPTH entries -> A_READY=0 at count 4; a 5th VALID is not accepted until the count drops. Data order is intact.
- $0 discard: A pushes addr 0 with data 0xFFFF -> A_READY stays 1, A_COUNT stays 0, WEA3 never asserts.

Source files
------------

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback request and register-file write-port bundle for regfile_wb_scheduler.
// The master side is the producer of requests and the consumer of write-port
// outputs. The slave side is the scheduler itself.
interface regfile_wb_scheduler_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    // core A request channel
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;

    // core B request channel
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;

    // register file write ports
    logic          wea3;
    logic [AW-1:0] a3;
    logic [DW-1:0] wda3;
    logic          web3;
    logic [AW-1:0] b3;
    logic [DW-1:0] wdb3;

    // occupancy and hazard visibility
    logic [CW-1:0] a_count;
    logic [CW-1:0] b_count;
    logic [31:0]   pend_mask;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  wea3, a3, wda3, web3, b3, wdb3,
        input  a_count, b_count, pend_mask
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output wea3, a3, wda3, web3, b3, wdb3,
        output a_count, b_count, pend_mask
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Write-side front end for the dual-port register file shared by two cores.
// Each core owns a small FIFO of (register, data) writebacks. Every cycle the
// scheduler drains the FIFO heads onto the two register-file write ports.
// Core A always uses port A and core B always uses port B. When both heads
// target the same register, only one side issues that cycle, and a round-robin
// priority bit decides which. A pending-write mask covers every register that
// is still queued or is currently on a write port, so hazard logic can stall.
module regfile_wb_scheduler #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_wb_scheduler_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    // FIFO storage and pointers
    entry_t        mem_a [DEPTH];
    entry_t        mem_b [DEPTH];
    logic [PW-1:0] wr_a, rd_a, wr_b, rd_b;
    logic [CW-1:0] cnt_a, cnt_b;

    // scheduler state and registered write ports
    prio_t         prio;
    logic          we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;

    // combinational decisions for the coming edge
    entry_t        head_a, head_b;
    logic          ready_a, ready_b;
    logic          push_a, push_b;
    logic          nonempty_a, nonempty_b;
    logic          same_addr, collide;
    logic          pop_a, pop_b;
    logic [31:0]   pend;

    // Handshake and issue decisions. Both are based only on state from before the edge.
    // A full FIFO refuses pushes even if it pops on the same edge. Register 0 is
    // accepted at the handshake but never stored, because writes to it have no effect.
    always_comb begin
        head_a     = mem_a[rd_a];
        head_b     = mem_b[rd_b];
        ready_a    = (cnt_a != CW'(DEPTH));
        ready_b    = (cnt_b != CW'(DEPTH));
        push_a     = bus.a_valid && ready_a && (bus.a_addr != '0);
        push_b     = bus.b_valid && ready_b && (bus.b_addr != '0);
        nonempty_a = (cnt_a != '0);
        nonempty_b = (cnt_b != '0);
        same_addr  = (head_a.addr == head_b.addr);
        collide    = nonempty_a && nonempty_b && same_addr;
        pop_a      = nonempty_a && (!collide || (prio == PRIO_A));
        pop_b      = nonempty_b && (!collide || (prio == PRIO_B));
    end

    // Core A FIFO bookkeeping. The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_a  <= '0;
            rd_a  <= '0;
            cnt_a <= '0;
        end else begin
            if (push_a) wr_a <= wr_a + PW'(1);
            if (pop_a)  rd_a <= rd_a + PW'(1);
            cnt_a <= cnt_a + CW'(push_a) - CW'(pop_a);
        end
    end

    // Core B FIFO bookkeeping, mirroring core A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_b  <= '0;
            rd_b  <= '0;
            cnt_b <= '0;
        end else begin
            if (push_b) wr_b <= wr_b + PW'(1);
            if (pop_b)  rd_b <= rd_b + PW'(1);
            cnt_b <= cnt_b + CW'(push_b) - CW'(pop_b);
        end
    end

    // FIFO payload storage. It has no reset because the counts and pointers decide which slots are live.
    always_ff @(posedge clk) begin
        if (push_a) mem_a[wr_a] <= '{addr: bus.a_addr, data: bus.a_data};
        if (push_b) mem_b[wr_b] <= '{addr: bus.b_addr, data: bus.b_data};
    end

    // Issue stage and round-robin state. Write enables pulse for one cycle per entry.
    // Address and data registers hold their last values while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio   <= PRIO_A;
            we_a   <= 1'b0;
            we_b   <= 1'b0;
            addr_a <= '0;
            addr_b <= '0;
            data_a <= '0;
            data_b <= '0;
        end else begin
            we_a <= pop_a;
            we_b <= pop_b;
            if (pop_a) begin
                addr_a <= head_a.addr;
                data_a <= head_a.data;
            end
            if (pop_b) begin
                addr_b <= head_b.addr;
                data_b <= head_b.data;
            end
            if (collide) begin
                prio <= (prio == PRIO_A) ? PRIO_B : PRIO_A;
            end
        end
    end

    // Pending-write mask. A slot is live when its distance from the read pointer is below
    // the count. The mask also includes any register currently on a write port.
    always_comb begin
        logic [PW-1:0] off_a;
        logic [PW-1:0] off_b;
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off_a = PW'(i) - rd_a;
            off_b = PW'(i) - rd_b;
            if ({1'b0, off_a} < cnt_a) pend = pend | (32'd1 << mem_a[i].addr);
            if ({1'b0, off_b} < cnt_b) pend = pend | (32'd1 << mem_b[i].addr);
        end
        if (we_a) pend = pend | (32'd1 << addr_a);
        if (we_b) pend = pend | (32'd1 << addr_b);
        pend[0] = 1'b0;
    end

    assign bus.a_ready   = ready_a;
    assign bus.b_ready   = ready_b;
    assign bus.wea3      = we_a;
    assign bus.a3        = addr_a;
    assign bus.wda3      = data_a;
    assign bus.web3      = we_b;
    assign bus.b3        = addr_b;
    assign bus.wdb3      = data_b;
    assign bus.a_count   = cnt_a;
    assign bus.b_count   = cnt_b;
    assign bus.pend_mask = pend;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler.
// A queue-based reference model runs in parallel with the DUT. Accepted
// writebacks are pushed into per-port scoreboards, and those scoreboards are
// popped as the DUT raises its write enables. A vector table and hand-written
// sequences cover reset, collisions and backpressure.
module tb_regfile_wb_scheduler;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    regfile_wb_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } log_t;

    wr_t  mdl_a [$];
    wr_t  mdl_b [$];
    wr_t  sb_a  [$];
    wr_t  sb_b  [$];
    log_t issue_log [$];

    logic          m_prio, m_wea3, m_web3, m_acc_a, m_acc_b;
    logic [AW-1:0] m_a3, m_b3;
    logic [DW-1:0] m_wda3, m_wdb3;
    logic          h_a_ne, h_b_ne, h_same, h_pop_a, h_pop_b, h_rdy_a, h_rdy_b;
    wr_t           h_a, h_b;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelPend();
        logic [31:0] m;
        m = '0;
        foreach (mdl_a[i]) m[mdl_a[i].addr] = 1'b1;
        foreach (mdl_b[i]) m[mdl_b[i].addr] = 1'b1;
        if (m_wea3) m[m_a3] = 1'b1;
        if (m_web3) m[m_b3] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Reference model: writes issue from the queue heads, a collision lets the
    // favoured side through and flips the favour, and pushes are admitted only
    // when the queue was not full before the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_a.delete();
            mdl_b.delete();
            sb_a.delete();
            sb_b.delete();
            m_prio  = 1'b0;
            m_wea3  = 1'b0;
            m_web3  = 1'b0;
            m_a3    = '0;
            m_b3    = '0;
            m_wda3  = '0;
            m_wdb3  = '0;
            m_acc_a = 1'b0;
            m_acc_b = 1'b0;
        end else begin
            h_rdy_a = (mdl_a.size() != DEPTH);
            h_rdy_b = (mdl_b.size() != DEPTH);
            h_a_ne  = (mdl_a.size() > 0);
            h_b_ne  = (mdl_b.size() > 0);
            if (h_a_ne) h_a = mdl_a[0];
            if (h_b_ne) h_b = mdl_b[0];
            h_same  = h_a_ne && h_b_ne && (h_a.addr == h_b.addr);
            h_pop_a = h_a_ne && (!h_same || !m_prio);
            h_pop_b = h_b_ne && (!h_same || m_prio);
            if (h_same) m_prio = !m_prio;
            m_wea3 = h_pop_a;
            m_web3 = h_pop_b;
            if (h_pop_a) begin
                void'(mdl_a.pop_front());
                m_a3   = h_a.addr;
                m_wda3 = h_a.data;
            end
            if (h_pop_b) begin
                void'(mdl_b.pop_front());
                m_b3   = h_b.addr;
                m_wdb3 = h_b.data;
            end
            m_acc_a = bus.a_valid && h_rdy_a;
            m_acc_b = bus.b_valid && h_rdy_b;
            if (m_acc_a && bus.a_addr != '0) begin
                mdl_a.push_back('{addr: bus.a_addr, data: bus.a_data});
                sb_a.push_back('{addr: bus.a_addr, data: bus.a_data});
            end
            if (m_acc_b && bus.b_addr != '0) begin
                mdl_b.push_back('{addr: bus.b_addr, data: bus.b_data});
                sb_b.push_back('{addr: bus.b_addr, data: bus.b_data});
            end
        end
    end

    // Mid-cycle monitor: compare the DUT against the model and drain the scoreboards on each write enable.
    always @(negedge clk) begin
        wr_t e;
        checkOutput("wea3", bus.wea3, m_wea3);
        checkOutput("web3", bus.web3, m_web3);
        checkOutput("a3", bus.a3, m_a3);
        checkOutput("wda3", bus.wda3, m_wda3);
        checkOutput("b3", bus.b3, m_b3);
        checkOutput("wdb3", bus.wdb3, m_wdb3);
        checkOutput("a_count", bus.a_count, mdl_a.size());
        checkOutput("b_count", bus.b_count, mdl_b.size());
        checkOutput("a_ready", bus.a_ready, mdl_a.size() != DEPTH);
        checkOutput("b_ready", bus.b_ready, mdl_b.size() != DEPTH);
        checkOutput("pend_mask", bus.pend_mask, modelPend());
        if (bus.wea3 === 1'b1) begin
            issue_log.push_back('{port: 1'b0, data: bus.wda3});
            if (sb_a.size() == 0) begin
                mismatched++;
                compared++;
                $display("[TB] FAIL sb_a: got write r%0d=%0h expected none", bus.a3, bus.wda3);
            end else begin
                e = sb_a.pop_front();
                checkOutput("sb_a addr", bus.a3, e.addr);
                checkOutput("sb_a data", bus.wda3, e.data);
            end
        end
        if (bus.web3 === 1'b1) begin
            issue_log.push_back('{port: 1'b1, data: bus.wdb3});
            if (sb_b.size() == 0) begin
                mismatched++;
                compared++;
                $display("[TB] FAIL sb_b: got write r%0d=%0h expected none", bus.b3, bus.wdb3);
            end else begin
                e = sb_b.pop_front();
                checkOutput("sb_b addr", bus.b3, e.addr);
                checkOutput("sb_b data", bus.wdb3, e.data);
            end
        end
    end

    // Drive one request cycle. The task returns 1 time unit after the edge that samples the request.
    task automatic applyStimulus(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                 input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        @(negedge clk);
        #1;
        bus.a_valid = av;
        bus.a_addr  = aa;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_addr  = ba;
        bus.b_data  = bd;
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.a_count == '0 && bus.b_count == '0 && !bus.wea3 && !bus.web3) return;
        end
        compared++;
        mismatched++;
        $display("[TB] FAIL idle timeout: got counts %0d/%0d expected 0/0", bus.a_count, bus.b_count);
    endtask

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          bv;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic [CW-1:0] exp_ac;
        logic [CW-1:0] exp_bc;
        logic [31:0]   exp_pend_push;
        logic          exp_wea;
        logic          exp_web;
        logic [31:0]   exp_pend_issue;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int ai;
        int bi;
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'd0,   3'd1, 3'd0, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0020};
        tbl[1] = '{1'b1, 5'd3,  32'h1,        1'b1, 5'd4,  32'h2,   3'd1, 3'd1, 32'h0000_0018, 1'b1, 1'b1, 32'h0000_0018};
        tbl[2] = '{1'b1, 5'd0,  32'hFFFF,     1'b0, 5'd0,  32'd0,   3'd0, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
        tbl[3] = '{1'b1, 5'd7,  32'hAA,       1'b1, 5'd7,  32'hBB,  3'd1, 3'd1, 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0080};
        tbl[4] = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd9,  32'h9B9, 3'd1, 3'd1, 32'h0000_0200, 1'b0, 1'b1, 32'h0000_0200};
        tbl[5] = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd31, 32'h31,  3'd1, 3'd1, 32'h8000_0002, 1'b1, 1'b1, 32'h8000_0002};
        tbl[6] = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd12, 32'hC,   3'd0, 3'd1, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_1000};
        tbl[7] = '{1'b1, 5'd0,  32'h5,        1'b1, 5'd0,  32'h6,   3'd0, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};

        bus.a_valid = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset wea3", bus.wea3, 1'b0);
        checkOutput("reset web3", bus.web3, 1'b0);
        checkOutput("reset a_count", bus.a_count, 0);
        checkOutput("reset b_count", bus.b_count, 0);
        checkOutput("reset pend", bus.pend_mask, 0);
        checkOutput("reset a3", bus.a3, 0);
        checkOutput("reset wdb3", bus.wdb3, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Vector table: each vector starts from empty FIFOs.
        for (int v = 0; v < 8; v++) begin
            waitIdle();
            applyStimulus(tbl[v].av, tbl[v].aa, tbl[v].ad, tbl[v].bv, tbl[v].ba, tbl[v].bd);
            checkOutput($sformatf("v%0d a_count", v), bus.a_count, tbl[v].exp_ac);
            checkOutput($sformatf("v%0d b_count", v), bus.b_count, tbl[v].exp_bc);
            checkOutput($sformatf("v%0d pend push", v), bus.pend_mask, tbl[v].exp_pend_push);
            checkOutput($sformatf("v%0d a_ready", v), bus.a_ready, 1'b1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d wea3", v), bus.wea3, tbl[v].exp_wea);
            checkOutput($sformatf("v%0d web3", v), bus.web3, tbl[v].exp_web);
            checkOutput($sformatf("v%0d pend issue", v), bus.pend_mask, tbl[v].exp_pend_issue);
            if (tbl[v].exp_wea) begin
                checkOutput($sformatf("v%0d a3", v), bus.a3, tbl[v].aa);
                checkOutput($sformatf("v%0d wda3", v), bus.wda3, tbl[v].ad);
            end
            if (tbl[v].exp_web) begin
                checkOutput($sformatf("v%0d b3", v), bus.b3, tbl[v].ba);
                checkOutput($sformatf("v%0d wdb3", v), bus.wdb3, tbl[v].bd);
            end
        end
        waitIdle();

        // Reset in mid-stream while several colliding entries are still queued.
        applyStimulus(1'b1, 5'd8, 32'h1, 1'b1, 5'd8, 32'h11);
        applyStimulus(1'b1, 5'd8, 32'h2, 1'b1, 5'd8, 32'h12);
        applyStimulus(1'b1, 5'd8, 32'h3, 1'b1, 5'd8, 32'h13);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst wea3", bus.wea3, 1'b0);
        checkOutput("midrst web3", bus.web3, 1'b0);
        checkOutput("midrst a_count", bus.a_count, 0);
        checkOutput("midrst b_count", bus.b_count, 0);
        checkOutput("midrst pend", bus.pend_mask, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checkOutput("post-reset wea3", bus.wea3, 1'b0);
            checkOutput("post-reset web3", bus.web3, 1'b0);
        end

        // Collision fairness: after reset, priority starts with core A.
        issue_log.delete();
        applyStimulus(1'b1, 5'd7, 32'hA1, 1'b1, 5'd7, 32'hB1);
        applyStimulus(1'b1, 5'd7, 32'hA2, 1'b1, 5'd7, 32'hB2);
        waitIdle();
        checkOutput("collide log size", issue_log.size(), 4);
        if (issue_log.size() >= 4) begin
            checkOutput("collide 0 port", issue_log[0].port, 1'b0);
            checkOutput("collide 0 data", issue_log[0].data, 32'hA1);
            checkOutput("collide 1 port", issue_log[1].port, 1'b1);
            checkOutput("collide 1 data", issue_log[1].data, 32'hB1);
            checkOutput("collide 2 port", issue_log[2].port, 1'b0);
            checkOutput("collide 2 data", issue_log[2].data, 32'hA2);
            checkOutput("collide 3 port", issue_log[3].port, 1'b1);
            checkOutput("final r7", issue_log[3].data, 32'hB2);
        end

        // Backpressure: continuous collisions on r10 fill core A's FIFO. A request is held until it is accepted.
        ai = 0;
        bi = 0;
        for (int c = 0; c < 60 && (ai < 8 || bi < 8); c++) begin
            applyStimulus(ai < 8, 5'd10, 32'h100 + ai, bi < 8, 5'd10, 32'h200 + bi);
            if (m_acc_a) ai++;
            if (m_acc_b) bi++;
            if (mdl_a.size() == DEPTH) begin
                checkOutput("full a_ready", bus.a_ready, 1'b0);
                checkOutput("full a_count", bus.a_count, DEPTH);
            end
        end
        if (ai < 8 || bi < 8) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL backpressure timeout: got %0d/%0d accepted expected 8/8", ai, bi);
        end
        waitIdle();
        checkOutput("sb_a drained", sb_a.size(), 0);
        checkOutput("sb_b drained", sb_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
